// File: rtl/timer_switch_ctrl_if.sv
// Button/lamp signal bundle between the button conditioner, the timer switch and the lamp driver.
// The master side supplies the button level; the slave side (the controller) drives the lamp.
interface timer_switch_ctrl_if #(
    parameter int unsigned CW = 6
);
    logic          btn;
    logic          lamp;
    logic          warn;
    logic          manual;
    logic [CW-1:0] remaining;

    modport master (
        output btn,
        input  lamp,
        input  warn,
        input  manual,
        input  remaining
    );

    modport slave (
        input  btn,
        output lamp,
        output warn,
        output manual,
        output remaining
    );
endinterface

// File: rtl/timer_switch_ctrl.sv
// Staircase-light timer switch: timed lamp with retrigger, blinking pre-off warning
// and a long-press permanent-on mode. Outputs decode registers only.
module timer_switch_ctrl #(
    parameter int unsigned PRESCALE   = 1000,
    parameter int unsigned ON_TICKS   = 60,
    parameter int unsigned WARN_TICKS = 5,
    parameter int unsigned LONG_TICKS = 3
) (
    input logic             clock,
    input logic             reset_n,
    timer_switch_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(ON_TICKS + 1);
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned HW = $clog2(LONG_TICKS + 1);

    localparam logic [1:0] StOff    = 2'd0;
    localparam logic [1:0] StOn     = 2'd1;
    localparam logic [1:0] StWarn   = 2'd2;
    localparam logic [1:0] StManual = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] rem_q, rem_d, rem_dec;
    logic [PW-1:0] pc_q, pc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          blink_q, blink_d;
    logic          btn_q;
    logic          rise, run, tick, long_press;

    assign rise    = bus.btn & ~btn_q;
    assign run     = (state_q == StOn) || (state_q == StWarn);
    assign tick    = run && (pc_q == PW'(PRESCALE - 1));
    assign rem_dec = rem_q - CW'(1);
    // The tick that would bring the hold count to LONG_TICKS completes the long press.
    assign long_press = run && bus.btn && !rise && tick && (hold_q == HW'(LONG_TICKS - 1));

    always_comb begin
        pc_d = pc_q + PW'(1);
        if (rise || !run || tick) begin
            pc_d = '0;
        end
    end

    always_comb begin
        hold_d = hold_q;
        if (!bus.btn || rise) begin
            hold_d = '0;
        end else if (tick && (hold_q != HW'(LONG_TICKS))) begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        blink_d = blink_q;
        if (rise) begin
            if (state_q == StManual) begin
                state_d = StOff;
                rem_d   = '0;
            end else begin
                state_d = StOn;
                rem_d   = CW'(ON_TICKS);
            end
        end else if (long_press) begin
            state_d = StManual;
            rem_d   = '0;
        end else if (tick) begin
            rem_d = rem_dec;
            if (state_q == StOn) begin
                if (rem_dec == CW'(WARN_TICKS)) begin
                    state_d = StWarn;
                    blink_d = 1'b0;
                end
            end else begin
                blink_d = ~blink_q;
                if (rem_dec == '0) begin
                    state_d = StOff;
                end
            end
        end
    end

    // btn_q resets high so a button held through reset does not look like a press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StOff;
            rem_q   <= '0;
            pc_q    <= '0;
            hold_q  <= '0;
            blink_q <= 1'b0;
            btn_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            blink_q <= blink_d;
            btn_q   <= bus.btn;
        end
    end

    assign bus.lamp      = (state_q == StOn) || (state_q == StManual) ||
                           ((state_q == StWarn) && blink_q);
    assign bus.warn      = (state_q == StWarn);
    assign bus.manual    = (state_q == StManual);
    assign bus.remaining = rem_q;
endmodule
